// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: a valid/ready request carrying operand, distance
// and mode, and a valid/ready response carrying the shifted word and its flags.
interface shift_unit_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned AMT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     data_a;
  logic [AMT_W-1:0] amount;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             carry_o;
  logic             zero_o;

  modport master (
    output in_valid, data_a, amount, mode, out_ready,
    input  in_ready, out_valid, result, carry_o, zero_o
  );

  modport slave (
    input  in_valid, data_a, amount, mode, out_ready,
    output in_ready, out_valid, result, carry_o, zero_o
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle barrel-free shifter: one bit per clock for LSL/ROL/LSR/ROR/ASR, with the last
// bit shifted out reported as carry and a zero flag on the held result.
module shift_unit #(
  parameter int unsigned W     = 8,
  parameter int unsigned AMT_W = 8
) (
  input logic         clk,
  input logic         reset_n,
  shift_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(W) + 1;
  localparam int unsigned XW    = (AMT_W > 32) ? AMT_W : 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_ROL = 3'b001;
  localparam logic [2:0] MODE_LSR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic [2:0]       mode_q, mode_d;

  logic [XW-1:0]    amt_ext;
  logic [CNT_W-1:0] eff;
  logic [W-1:0]     shifted;
  logic             shift_out;

  assign amt_ext = XW'(bus.amount);

  // Logical/arithmetic shifts saturate at W; rotates wrap modulo W (W is a power of two).
  always_comb begin
    eff = '0;
    case (bus.mode)
      MODE_LSL, MODE_LSR, MODE_ASR:
        eff = (amt_ext >= XW'(W)) ? CNT_W'(W) : CNT_W'(amt_ext);
      MODE_ROL, MODE_ROR:
        eff = CNT_W'(amt_ext & XW'(W - 1));
      default: eff = '0;
    endcase
  end

  always_comb begin
    shifted   = res_q;
    shift_out = 1'b0;
    case (mode_q)
      MODE_LSL: begin shifted = {res_q[W-2:0], 1'b0};        shift_out = res_q[W-1]; end
      MODE_ROL: begin shifted = {res_q[W-2:0], res_q[W-1]};  shift_out = res_q[W-1]; end
      MODE_LSR: begin shifted = {1'b0, res_q[W-1:1]};        shift_out = res_q[0];   end
      MODE_ROR: begin shifted = {res_q[0], res_q[W-1:1]};    shift_out = res_q[0];   end
      MODE_ASR: begin shifted = {res_q[W-1], res_q[W-1:1]};  shift_out = res_q[0];   end
      default:  begin shifted = res_q;                       shift_out = 1'b0;       end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          res_d   = bus.data_a;
          mode_d  = bus.mode;
          carry_d = 1'b0;
          cnt_d   = eff;
          state_d = (eff == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        res_d   = shifted;
        carry_d = shift_out;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry_o   = carry_q;
  assign bus.zero_o    = (res_q == '0);

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (W=8, AMT_W=8): each task drives one scenario and checks
// latency, result, carry and zero flags against hand-computed values.
module tb_shift_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  shift_unit_if #(.W(8), .AMT_W(8)) bus ();

  shift_unit #(.W(8), .AMT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; assumes the unit is idle.
  task automatic send(input logic [2:0] m, input logic [7:0] d, input logic [7:0] amt);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.data_a   = d;
    bus.amount   = amt;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded to 50.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 ||
        bus.carry_o !== 1'b0 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b res=%h c=%b z=%b expected rdy=1 vld=0 res=00 c=0 z=1",
               bus.in_ready, bus.out_valid, bus.result, bus.carry_o, bus.zero_o);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_lsl();
    int e;
    send(3'b000, 8'h81, 8'd1);
    wait_done(e);
    checks++;
    if (e !== 1 || bus.result !== 8'h02 || bus.carry_o !== 1'b1 || bus.zero_o !== 1'b0) begin
      errors++;
      $display("FAIL lsl_81_1: edges=%0d res=%h c=%b z=%b expected 1 02 1 0",
               e, bus.result, bus.carry_o, bus.zero_o);
    end
    pop();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsl_pop: rdy=%b vld=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_rol_ror();
    int e;
    send(3'b001, 8'h81, 8'd9);
    wait_done(e);
    checks++;
    if (e !== 1 || bus.result !== 8'h03 || bus.carry_o !== 1'b1) begin
      errors++;
      $display("FAIL rol_81_9: edges=%0d res=%h c=%b expected 1 03 1", e, bus.result, bus.carry_o);
    end
    pop();
    send(3'b011, 8'h01, 8'd8);
    wait_done(e);
    checks++;
    if (e !== 0 || bus.result !== 8'h01 || bus.carry_o !== 1'b0 || bus.zero_o !== 1'b0) begin
      errors++;
      $display("FAIL ror_01_8: edges=%0d res=%h c=%b z=%b expected 0 01 0 0",
               e, bus.result, bus.carry_o, bus.zero_o);
    end
    pop();
  endtask

  task automatic test_asr_lsr();
    int e;
    send(3'b100, 8'h80, 8'd200);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL asr_busy[%0d]: rdy=%b vld=%b expected 0 0", i, bus.in_ready, bus.out_valid);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'hFF || bus.carry_o !== 1'b1) begin
      errors++;
      $display("FAIL asr_80_200: vld=%b res=%h c=%b expected 1 ff 1",
               bus.out_valid, bus.result, bus.carry_o);
    end
    pop();
    send(3'b010, 8'h80, 8'd200);
    wait_done(e);
    checks++;
    if (e !== 8 || bus.result !== 8'h00 || bus.carry_o !== 1'b1 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL lsr_80_200: edges=%0d res=%h c=%b z=%b expected 8 00 1 1",
               e, bus.result, bus.carry_o, bus.zero_o);
    end
    pop();
    send(3'b000, 8'hFF, 8'd255);
    wait_done(e);
    checks++;
    if (e !== 8 || bus.result !== 8'h00 || bus.carry_o !== 1'b1) begin
      errors++;
      $display("FAIL lsl_ff_255: edges=%0d res=%h c=%b expected 8 00 1", e, bus.result, bus.carry_o);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    int e;
    send(3'b010, 8'h55, 8'd3);
    wait_done(e);
    checks++;
    if (e !== 3 || bus.result !== 8'h0A || bus.carry_o !== 1'b1 || bus.zero_o !== 1'b0) begin
      errors++;
      $display("FAIL lsr_55_3: edges=%0d res=%h c=%b z=%b expected 3 0a 1 0",
               e, bus.result, bus.carry_o, bus.zero_o);
    end
    // Stall the consumer while toggling in_valid with a different request.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.mode     = 3'b000;
      bus.data_a   = 8'hA5;
      bus.amount   = 8'd2;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 8'h0A ||
          bus.carry_o !== 1'b1 || bus.zero_o !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b rdy=%b res=%h c=%b z=%b expected 1 0 0a 1 0",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.carry_o, bus.zero_o);
      end
    end
    // Handshake edge with a new request already pending: it must not be taken on that edge.
    bus.in_valid  = 1'b1;
    bus.data_a    = 8'h01;
    bus.amount    = 8'd1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: rdy=%b vld=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: rdy=%b vld=%b expected 0 0", bus.in_ready, bus.out_valid);
    end
    wait_done(e);
    checks++;
    if (e !== 1 || bus.result !== 8'h02 || bus.carry_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: edges=%0d res=%h c=%b expected 1 02 0", e, bus.result, bus.carry_o);
    end
    pop();
  endtask

  task automatic test_reserved();
    int e;
    send(3'b110, 8'h3C, 8'd5);
    wait_done(e);
    checks++;
    if (e !== 0 || bus.result !== 8'h3C || bus.carry_o !== 1'b0 || bus.zero_o !== 1'b0) begin
      errors++;
      $display("FAIL reserved_110: edges=%0d res=%h c=%b z=%b expected 0 3c 0 0",
               e, bus.result, bus.carry_o, bus.zero_o);
    end
    pop();
  endtask

  task automatic test_reset_mid_busy();
    int e;
    send(3'b000, 8'hF0, 8'd6);
    tick();
    tick();
    checks++;
    if (bus.result !== 8'hC0 || bus.carry_o !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_2_shifts: res=%h c=%b rdy=%b expected c0 1 0",
               bus.result, bus.carry_o, bus.in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 8'h00 || bus.carry_o !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: res=%h c=%b vld=%b rdy=%b z=%b expected 00 0 0 1 1",
               bus.result, bus.carry_o, bus.out_valid, bus.in_ready, bus.zero_o);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset[%0d]: vld=%b rdy=%b expected 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
    send(3'b000, 8'h01, 8'd2);
    wait_done(e);
    checks++;
    if (e !== 2 || bus.result !== 8'h04 || bus.carry_o !== 1'b0) begin
      errors++;
      $display("FAIL lsl_01_2: edges=%0d res=%h c=%b expected 2 04 0", e, bus.result, bus.carry_o);
    end
    pop();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_a    = '0;
    bus.amount    = '0;
    bus.mode      = '0;
    test_reset();
    test_lsl();
    test_rol_ror();
    test_asr_lsr();
    test_back_to_back();
    test_reserved();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter W, default 8, data width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter AMT_W, default 8, shift-amount width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on data_a/amount/mode.
REQ-006 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 data_a  input  W  operand to shift.
REQ-008 amount  input  AMT_W  unsigned shift distance.
REQ-009 mode  input  3  000 LSL, 001 ROL, 010 LSR, 011 ROR, 100 ASR, 101-111 reserved.
REQ-010 out_valid  output  1  result, carry_o and zero_o are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  W  shifted operand.
REQ-013 carry_o  output  1  last bit moved out of the word; 0 if no shift was done.
REQ-014 zero_o  output  1  high when result == 0.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready; data_a, mode and the effective count (eff) are latched at that edge.
REQ-017 eff for LSL/LSR/ASR SHALL be min(amount, W).
REQ-018 eff for ROL/ROR SHALL be amount mod W.
REQ-019 eff for reserved modes SHALL be 0, giving result = data_a and carry_o = 0.
REQ-020 On accept, the next state SHALL be DONE if eff == 0, else BUSY with the counter loaded to eff; carry_o is cleared to 0.
REQ-021 Each BUSY edge SHALL perform a 1-bit shift and decrement the counter.
REQ-022 LSL inserts 0 at the LSB; LSR inserts 0 at the MSB; ASR inserts the current MSB; ROL moves the MSB to the LSB; ROR moves the LSB to the MSB.
REQ-023 On each BUSY edge, carry_o SHALL capture the bit leaving the word: the MSB for LSL/ROL, the LSB for LSR/ROR/ASR.
REQ-024 On the BUSY edge where the counter goes 1 to 0, the state SHALL become DONE; out_valid therefore rises exactly eff edges after the accept edge (0 edges when eff == 0).
REQ-025 In DONE, result, carry_o and zero_o SHALL hold stable until out_valid && out_ready; on that edge the state returns to IDLE.
REQ-026 in_valid SHALL be ignored in BUSY and DONE; a new accept is possible no earlier than the edge after the output handshake.
REQ-027 amount values of W or greater SHALL NOT wrap for the logical and arithmetic shifts (LSL 0xFF by 255 with W=8 gives 0x00).
REQ-028 zero_o SHALL be derived combinationally from the result register.

Reset
REQ-029 While reset_n is low, regardless of clk, the state SHALL be IDLE, the counter 0, result 0, carry_o 0, out_valid 0 and in_ready 1.
REQ-030 Reset asserted in BUSY or DONE SHALL discard the operation with no output handshake; the first accept is possible on the first rising edge after reset_n goes high.

Verification (W=8, AMT_W=8)
REQ-031 LSL 0x81 by 1 -> out_valid 1 edge after accept, result 0x02, carry_o 1, zero_o 0.
REQ-032 ROL 0x81 by 9 (eff 1) -> result 0x03, carry_o 1; then ROR 0x01 by 8 (eff 0) -> out_valid right after the accept edge, result 0x01, carry_o 0.
REQ-033 ASR 0x80 by 200 (eff 8) -> in_ready low for 8 BUSY edges, then result 0xFF, carry_o 1; LSR 0x80 by 200 -> result 0x00, carry_o 1, zero_o 1.
REQ-034 LSR 0x55 by 3 with out_ready held low 5 cycles after out_valid -> result 0x0A, carry_o 1, all outputs stable, in_valid pulses ignored, IDLE one edge after out_ready goes high.
REQ-035 Reserved mode 110 with data_a 0x3C, amount 5 -> DONE immediately, result 0x3C, carry_o 0.
REQ-036 reset_n pulsed low mid-BUSY (LSL 0xF0 by 6, after 2 shifts) -> outputs go to reset values immediately with no clock edge, no out_valid; a subsequent LSL 0x01 by 2 gives 0x04.
